// File: rtl/skew_fifo_pkg.sv
// Shared types and helpers for the skewed channel FIFO array.
package skew_fifo_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE   = 2'b00,
        CTRL_LOAD   = 2'b01,
        CTRL_WRITE  = 2'b10,
        CTRL_STREAM = 2'b11
    } ctrl_e;

    // Index width for n entries, never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/skew_fifo_array_if.sv
// Control, data and status bundle of the skewed channel FIFO array.
interface skew_fifo_array_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4
) ();
    localparam int unsigned SEL_W = skew_fifo_pkg::ptr_width(CHANNELS);

    logic [1:0]                           ctrl_code;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]  data_in;
    logic [DATA_WIDTH-1:0]                data_write;
    logic [SEL_W-1:0]                     wr_sel;
    logic                                 clear_err;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]  data_out;
    logic [CHANNELS-1:0]                  out_valid;
    logic [CHANNELS-1:0]                  fifo_full;
    logic [CHANNELS-1:0]                  fifo_empty;
    logic [CHANNELS-1:0]                  fifo_threshold;
    logic [CHANNELS-1:0]                  fifo_overflow;
    logic [CHANNELS-1:0]                  fifo_underflow;
    logic                                 busy;

    modport master (
        output ctrl_code, data_in, data_write, wr_sel, clear_err,
        input  data_out, out_valid, fifo_full, fifo_empty, fifo_threshold,
               fifo_overflow, fifo_underflow, busy
    );

    modport slave (
        input  ctrl_code, data_in, data_write, wr_sel, clear_err,
        output data_out, out_valid, fifo_full, fifo_empty, fifo_threshold,
               fifo_overflow, fifo_underflow, busy
    );

endinterface

// File: rtl/chan_fifo.sv
// One channel FIFO: storage, pointers, count, registered flags and a registered pop port.
module chan_fifo
    import skew_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned THRESHOLD  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_req_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_req_i,
    input  logic                  clear_err_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  threshold_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q, threshold_q;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  do_push, do_pop;

    always_comb begin
        do_push     = wr_req_i & ~full_q;
        do_pop      = rd_req_i & ~empty_q;
        wr_ptr_d    = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
        // A fresh error outranks a simultaneous clear.
        overflow_d  = (overflow_q & ~clear_err_i) | (wr_req_i & full_q);
        underflow_d = (underflow_q & ~clear_err_i) | (rd_req_i & empty_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            threshold_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
            threshold_q <= (count_d >= CW'(THRESHOLD));
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_data_q   <= do_pop ? mem_q[rd_ptr_q] : '0;
            rd_valid_q  <= do_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign threshold_o = threshold_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/skew_fifo_array.sv
// Array of channel FIFOs feeding a systolic skew: channel c lags channel 0 by c cycles.
module skew_fifo_array
    import skew_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned THRESHOLD  = 4
) (
    input logic               clk,
    input logic               reset_n,
    skew_fifo_array_if.slave  bus
);
    localparam int unsigned SEL_W = ptr_width(CHANNELS);

    ctrl_e                               ctrl;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] data_out;
    logic [CHANNELS-1:0]                 out_valid;
    logic [CHANNELS-1:0]                 full, empty, threshold, overflow, underflow;
    logic [CHANNELS-1:0]                 chan_busy;

    assign ctrl = ctrl_e'(bus.ctrl_code);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic                  wr_req;
        logic [DATA_WIDTH-1:0] wr_data;
        logic [DATA_WIDTH-1:0] rd_data;
        logic                  rd_valid;
        // Entry 0 takes the popped word; entry c is the output register.
        logic [DATA_WIDTH-1:0] skew_data_q [c+1];
        logic [c:0]            skew_valid_q;

        // Out-of-range wr_sel never matches any channel and is ignored.
        assign wr_req  = (ctrl == CTRL_LOAD) ||
                         ((ctrl == CTRL_WRITE) && (bus.wr_sel == SEL_W'(c)));
        assign wr_data = (ctrl == CTRL_LOAD) ? bus.data_in[c] : bus.data_write;

        chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .THRESHOLD  (THRESHOLD)
        ) u_fifo (
            .clk         (clk),
            .reset_n     (reset_n),
            .wr_req_i    (wr_req),
            .wr_data_i   (wr_data),
            .rd_req_i    (ctrl == CTRL_STREAM),
            .clear_err_i (bus.clear_err),
            .rd_data_o   (rd_data),
            .rd_valid_o  (rd_valid),
            .full_o      (full[c]),
            .empty_o     (empty[c]),
            .threshold_o (threshold[c]),
            .overflow_o  (overflow[c]),
            .underflow_o (underflow[c])
        );

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                skew_valid_q <= '0;
                for (int j = 0; j <= c; j++) begin
                    skew_data_q[j] <= '0;
                end
            end else begin
                skew_valid_q[0] <= rd_valid;
                skew_data_q[0]  <= rd_data;
                for (int j = 1; j <= c; j++) begin
                    skew_valid_q[j] <= skew_valid_q[j-1];
                    skew_data_q[j]  <= skew_data_q[j-1];
                end
            end
        end

        assign data_out[c]  = skew_data_q[c];
        assign out_valid[c] = skew_valid_q[c];
        assign chan_busy[c] = |skew_valid_q;
    end

    assign bus.data_out       = data_out;
    assign bus.out_valid      = out_valid;
    assign bus.fifo_full      = full;
    assign bus.fifo_empty     = empty;
    assign bus.fifo_threshold = threshold;
    assign bus.fifo_overflow  = overflow;
    assign bus.fifo_underflow = underflow;
    assign bus.busy           = |chan_busy;

endmodule

// File: tb/tb_skew_fifo_array.sv
// Directed bench for skew_fifo_array: status vector table plus skew/wrap/reset sequences.
module tb_skew_fifo_array;
    import skew_fifo_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    skew_fifo_array_if #(.DATA_WIDTH(8), .CHANNELS(4)) bus ();

    skew_fifo_array #(
        .DATA_WIDTH (8),
        .CHANNELS   (4),
        .DEPTH      (8),
        .THRESHOLD  (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ctrl, write data, write select, clear_err} -> {full, empty, threshold, overflow, underflow}
    typedef struct {
        logic [1:0]  ctrl;
        logic [7:0]  dw;
        logic [1:0]  sel;
        logic        clr;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step(input logic [1:0] c, input logic [31:0] din, input logic [7:0] dw,
                        input logic [1:0] sel, input logic clr);
        bus.ctrl_code  = c;
        bus.data_in    = din;
        bus.data_write = dw;
        bus.wr_sel     = sel;
        bus.clear_err  = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] status();
        return {bus.fifo_full, bus.fifo_empty, bus.fifo_threshold,
                bus.fifo_overflow, bus.fifo_underflow};
    endfunction

    initial begin
        logic [3:0]  exp_v;
        logic [31:0] exp_d;
        int          busy_cycles;

        vecs[0]  = '{2'b10, 8'h10, 2'd2, 1'b0, {4'h0, 4'hb, 4'h0, 4'h0, 4'h0}};
        vecs[1]  = '{2'b10, 8'h11, 2'd2, 1'b0, {4'h0, 4'hb, 4'h0, 4'h0, 4'h0}};
        vecs[2]  = '{2'b10, 8'h12, 2'd2, 1'b0, {4'h0, 4'hb, 4'h0, 4'h0, 4'h0}};
        vecs[3]  = '{2'b10, 8'h13, 2'd2, 1'b0, {4'h0, 4'hb, 4'h4, 4'h0, 4'h0}};
        vecs[4]  = '{2'b10, 8'h14, 2'd2, 1'b0, {4'h0, 4'hb, 4'h4, 4'h0, 4'h0}};
        vecs[5]  = '{2'b10, 8'h15, 2'd2, 1'b0, {4'h0, 4'hb, 4'h4, 4'h0, 4'h0}};
        vecs[6]  = '{2'b10, 8'h16, 2'd2, 1'b0, {4'h0, 4'hb, 4'h4, 4'h0, 4'h0}};
        vecs[7]  = '{2'b10, 8'h17, 2'd2, 1'b0, {4'h4, 4'hb, 4'h4, 4'h0, 4'h0}};
        vecs[8]  = '{2'b10, 8'h18, 2'd2, 1'b0, {4'h4, 4'hb, 4'h4, 4'h4, 4'h0}};
        vecs[9]  = '{2'b00, 8'h00, 2'd0, 1'b1, {4'h4, 4'hb, 4'h4, 4'h0, 4'h0}};
        vecs[10] = '{2'b10, 8'h55, 2'd2, 1'b1, {4'h4, 4'hb, 4'h4, 4'h4, 4'h0}};
        vecs[11] = '{2'b00, 8'h00, 2'd0, 1'b1, {4'h4, 4'hb, 4'h4, 4'h0, 4'h0}};

        // Reset state
        reset_n = 1'b0;
        step(CTRL_IDLE, '0, '0, '0, 1'b0);
        step(CTRL_IDLE, '0, '0, '0, 1'b0);
        check("reset_status", 64'(status()), 64'({4'h0, 4'hf, 4'h0, 4'h0, 4'h0}));
        check("reset_valid", 64'(bus.out_valid), 64'h0);
        check("reset_data", 64'(bus.data_out), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        reset_n = 1'b1;
        step(CTRL_IDLE, '0, '0, '0, 1'b0);

        // Vector load {1,2,3,4}, one stream cycle, then watch the diagonal emerge
        step(CTRL_LOAD, 32'h04030201, '0, '0, 1'b0);
        check("load_empty", 64'(bus.fifo_empty), 64'h0);
        step(CTRL_STREAM, '0, '0, '0, 1'b0);
        busy_cycles = 0;
        for (int t = 1; t <= 6; t++) begin
            step(CTRL_IDLE, '0, '0, '0, 1'b0);
            exp_v = (t <= 4) ? 4'(1 << (t - 1)) : 4'h0;
            exp_d = (t <= 4) ? 32'(t) << (8 * (t - 1)) : 32'h0;
            check($sformatf("diag_valid_t%0d", t), 64'(bus.out_valid), 64'(exp_v));
            check($sformatf("diag_data_t%0d", t), 64'(bus.data_out), 64'(exp_d));
            if (bus.busy) busy_cycles++;
        end
        check("diag_busy_cycles", 64'(busy_cycles), 64'd4);
        check("diag_status", 64'(status()), 64'({4'h0, 4'hf, 4'h0, 4'h0, 4'h0}));

        // Channel 2 fill, threshold, full, overflow, sticky clear
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ctrl, '0, vecs[i].dw, vecs[i].sel, vecs[i].clr);
            check($sformatf("vec%0d_status", i), 64'(status()), 64'(vecs[i].exp));
        end

        // Stream 8 cycles: channel 2 drains in order, 3 edges behind the pop
        for (int i = 0; i < 12; i++) begin
            step((i < 8) ? CTRL_STREAM : CTRL_IDLE, '0, '0, '0, 1'b0);
            exp_v = (i >= 3 && i <= 10) ? 4'h4 : 4'h0;
            exp_d = (i >= 3 && i <= 10) ? 32'(8'h10 + i - 3) << 16 : 32'h0;
            check($sformatf("ch2_valid_i%0d", i), 64'(bus.out_valid), 64'(exp_v));
            check($sformatf("ch2_data_i%0d", i), 64'(bus.data_out), 64'(exp_d));
        end
        check("ch2_drain_status", 64'(status()), 64'({4'h0, 4'hf, 4'h0, 4'h0, 4'hb}));
        step(CTRL_IDLE, '0, '0, '0, 1'b1);
        check("ch2_clear_unf", 64'(bus.fifo_underflow), 64'h0);

        // Stream on an empty array
        step(CTRL_STREAM, '0, '0, '0, 1'b0);
        check("empty_unf", 64'(bus.fifo_underflow), 64'hf);
        for (int t = 0; t < 4; t++) begin
            step(CTRL_IDLE, '0, '0, '0, 1'b0);
            check($sformatf("bubble_valid_t%0d", t), 64'(bus.out_valid), 64'h0);
            check($sformatf("bubble_data_t%0d", t), 64'(bus.data_out), 64'h0);
        end
        step(CTRL_STREAM, '0, '0, '0, 1'b1);
        check("unf_clear_collide", 64'(bus.fifo_underflow), 64'hf);
        step(CTRL_IDLE, '0, '0, '0, 1'b1);
        check("unf_clear", 64'(bus.fifo_underflow), 64'h0);

        // Channel 0 pointer wrap
        for (int i = 0; i < 6; i++) step(CTRL_WRITE, '0, 8'(8'ha0 + i), 2'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(CTRL_STREAM, '0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(CTRL_IDLE, '0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(CTRL_WRITE, '0, 8'(8'h20 + i), 2'd0, 1'b0);
        check("wrap_fill_empty", 64'(bus.fifo_empty), 64'he);
        for (int i = 0; i < 8; i++) begin
            step((i < 6) ? CTRL_STREAM : CTRL_IDLE, '0, '0, '0, 1'b0);
            exp_v = (i >= 1 && i <= 6) ? 4'h1 : 4'h0;
            exp_d = (i >= 1 && i <= 6) ? 32'(8'h20 + i - 1) : 32'h0;
            check($sformatf("wrap_valid_i%0d", i), 64'(bus.out_valid), 64'(exp_v));
            check($sformatf("wrap_data_i%0d", i), 64'(bus.data_out), 64'(exp_d));
        end
        check("wrap_empty", 64'(bus.fifo_empty), 64'hf);
        step(CTRL_IDLE, '0, '0, '0, 1'b1);

        // Vector-load overflow, then reset mid-stream with every channel half full
        for (int i = 0; i < 8; i++) step(CTRL_LOAD, 32'h44332211, '0, '0, 1'b0);
        check("vload_full", 64'(status()), 64'({4'hf, 4'h0, 4'hf, 4'h0, 4'h0}));
        step(CTRL_LOAD, 32'h99999999, '0, '0, 1'b0);
        check("vload_ovf", 64'(status()), 64'({4'hf, 4'h0, 4'hf, 4'hf, 4'h0}));
        for (int i = 0; i < 4; i++) step(CTRL_STREAM, '0, '0, '0, 1'b0);
        check("half_status", 64'(status()), 64'({4'h0, 4'h0, 4'hf, 4'hf, 4'h0}));
        check("half_busy", 64'(bus.busy), 64'h1);
        reset_n = 1'b0;
        step(CTRL_STREAM, '0, '0, '0, 1'b0);
        check("midrst_status", 64'(status()), 64'({4'h0, 4'hf, 4'h0, 4'h0, 4'h0}));
        check("midrst_valid", 64'(bus.out_valid), 64'h0);
        check("midrst_data", 64'(bus.data_out), 64'h0);
        check("midrst_busy", 64'(bus.busy), 64'h0);
        reset_n = 1'b1;
        step(CTRL_IDLE, '0, '0, '0, 1'b0);
        check("post_rst_status", 64'(status()), 64'({4'h0, 4'hf, 4'h0, 4'h0, 4'h0}));
        check("post_rst_valid", 64'(bus.out_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/skew_fifo_array.md
SKEW_FIFO_ARRAY -- requirements
Module: skew_fifo_array

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent channel FIFOs (systolic rows).
REQ-003 SHALL have parameter DEPTH, default 8, words per channel; power of two, at least 2.
REQ-004 SHALL have parameter THRESHOLD, default 4, fill level that asserts fifo_threshold; range 1..DEPTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port ctrl_code, input, 2 bits: 00 idle, 01 vector load, 10 single write, 11 stream.
REQ-008 SHALL have port data_in, input, CHANNELS x DATA_WIDTH: vector-load data, element c to channel c.
REQ-009 SHALL have port data_write, input, DATA_WIDTH: single-write data.
REQ-010 SHALL have port wr_sel, input, clog2(CHANNELS) bits (minimum 1): single-write target channel.
REQ-011 SHALL have port clear_err, input, 1 bit: clears the sticky error flags.
REQ-012 SHALL have port data_out, output, CHANNELS x DATA_WIDTH: skewed stream data.
REQ-013 SHALL have port out_valid, output, CHANNELS bits: per-channel data_out qualifier.
REQ-014 SHALL have ports fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow, each output, CHANNELS bits, per-channel status.
REQ-015 SHALL have port busy, output, 1 bit: high while any skew stage holds valid data.

Function
REQ-016 Idle (00): FIFO contents, pointers and counts SHALL hold; the skew pipeline SHALL keep draining.
REQ-017 Vector load (01): each non-full channel c SHALL push data_in[c]; each full channel SHALL drop its word and set fifo_overflow[c].
REQ-018 Single write (10): channel wr_sel SHALL push data_write if not full, else drop it and set fifo_overflow[wr_sel]; wr_sel >= CHANNELS SHALL be ignored.
REQ-019 Stream (11): every non-empty channel SHALL pop one word per cycle; each empty channel SHALL set fifo_underflow[c] and inject an invalid bubble.
REQ-020 A word popped from channel c at edge k SHALL appear on data_out[c] with out_valid[c]=1 after edge k+1+c (c extra register stages of skew).
REQ-021 data_out[c] SHALL be zero whenever out_valid[c]=0.
REQ-022 Each channel SHALL preserve FIFO order; read/write pointers wrap modulo DEPTH; the count is PTR width+1 bits and ranges 0..DEPTH.
REQ-023 Status flags SHALL be registered: fifo_full[c]=(count==DEPTH), fifo_empty[c]=(count==0), fifo_threshold[c]=(count>=THRESHOLD).
REQ-024 fifo_overflow and fifo_underflow SHALL be sticky until clear_err=1; a new error in the clear_err cycle SHALL win (flag stays set).
REQ-025 busy SHALL equal the OR of all valid bits in the skew stages and output registers.
REQ-026 Leaving stream mode SHALL NOT flush the skew pipeline; words already popped SHALL still emerge.

Reset
REQ-027 With reset_n=0 at an edge, all pointers and counts SHALL clear, all skew stages SHALL clear, and data_out, out_valid, fifo_full, fifo_threshold, fifo_overflow, fifo_underflow and busy SHALL be 0.
REQ-028 During reset, fifo_empty SHALL be all ones; reset SHALL override every ctrl_code, including in mid-stream.

Structure
REQ-029 Package skew_fifo_pkg SHALL hold the ctrl_code enum (CTRL_IDLE, CTRL_LOAD, CTRL_WRITE, CTRL_STREAM) and the pointer-width helper function.
REQ-030 Sub-module chan_fifo (one channel: storage, pointers, count, flags) SHALL be instantiated CHANNELS times; skew registers SHALL sit in the top level.

Verification (DATA_WIDTH=8, CHANNELS=4, DEPTH=8, THRESHOLD=4)
REQ-031 Vector load {1,2,3,4} once, then stream one cycle -> ch0=1 valid one edge later, ch1=2 two edges later, ch2=3 three later, ch3=4 four later; busy high 4 cycles; no underflow.
REQ-032 Write 0x10..0x17 to ch2 -> threshold[2] after the 4th write, full[2] after the 8th; write 0x18 -> overflow[2]=1, word dropped; stream 8 cycles -> ch2 outputs 0x10..0x17 in order, first word 3 edges after stream start.
REQ-033 Stream on an empty array -> underflow=4'b1111, out_valid=0, data_out=0; pulse clear_err -> underflow=0.
REQ-034 Ch0: write 6, stream 6, write 0x20..0x25, stream 6 -> outputs 0x20..0x25 in order across pointer wrap; empty[0]=1 at the end.
REQ-035 Assert reset_n=0 mid-stream with all channels half full -> after the next edge out_valid=0, data_out=0, busy=0, empty=4'b1111, all error flags 0.
